// File: rtl/wb_burst_traffic_gen.sv
// ---------------------------------------------------------------------------
// wb_burst_traffic_gen
//
// Wishbone burst master for SDRAM soak testing. Each command issues one
// incrementing burst (write, read-check, or write followed by read-check).
// Write data comes from a seeded Galois LFSR. Read-check regenerates the same
// sequence from the seed, so the generator needs no data buffer.
//
// Ports
//   wb_clk_i / wb_rst_i  clock, asynchronous active-high reset
//   sdr_init_done        commands are only accepted once SDRAM init is done
//   cmd_*                command handshake (valid/ready), op, start word
//                        address, length (0 = 256 beats), LFSR seed (0 -> 1)
//   wb_*                 Wishbone master: cyc/stb/we/addr/dat/sel/cti out,
//                        ack/dat in
//   busy                 a command is in progress
//   done                 one-cycle pulse when a command finishes
//   timeout              sticky, set when a beat waited too long for ack
//   err_cnt              saturating read-check mismatch count
//   first_err_addr       word address of the first mismatch
// ---------------------------------------------------------------------------
module wb_burst_traffic_gen #(
    parameter int APP_AW      = 26,
    parameter int DW          = 32,
    parameter int ERR_W       = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [DW-1:0]     cmd_seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [APP_AW-1:0] first_err_addr
);

    localparam int              SW       = DW / 8;
    localparam int              WAIT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);
    localparam logic [DW-1:0]   POLY     = DW'(32'h0040_0007);

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_WR_RD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_GAP  = 3'd2,
        S_RD   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg;
    logic [APP_AW-1:0]  start_reg;
    logic [APP_AW-1:0]  addr_reg;
    logic [7:0]         len_m1_reg;
    logic [7:0]         beat_reg;
    logic [DW-1:0]      seed_reg;
    logic [DW-1:0]      lfsr_reg;
    logic [WAIT_W-1:0]  wait_reg;
    logic [ERR_W-1:0]   err_reg;
    logic [APP_AW-1:0]  first_reg;
    logic               timeout_reg;

    logic               accept;
    logic               in_burst;
    logic               ack_ok;
    logic               last_beat;
    logic               last_ack;
    logic               tmo_hit;
    logic               rd_mismatch;
    logic [DW-1:0]      lfsr_step;
    logic [DW-1:0]      seed_fix;

    // The bus is owned exactly while in WR or RD, so cyc/stb come straight
    // from the state register and drop on the same edge that leaves the burst
    // (or immediately on reset).
    assign in_burst    = (state_reg == S_WR) || (state_reg == S_RD);
    assign accept      = cmd_valid & cmd_ready;
    assign ack_ok      = in_burst & wb_ack_i;
    // len_m1 wraps 0 -> 255, which makes a zero length mean 256 beats.
    assign last_beat   = (beat_reg == len_m1_reg);
    assign last_ack    = ack_ok & last_beat;
    assign tmo_hit     = in_burst & ~wb_ack_i & (wait_reg == WAIT_MAX);
    assign rd_mismatch = (state_reg == S_RD) & ack_ok & (wb_dat_i != lfsr_reg);
    assign lfsr_step   = {lfsr_reg[DW-2:0], 1'b0} ^ (lfsr_reg[DW-1] ? POLY : '0);
    assign seed_fix    = (cmd_seed == '0) ? DW'(1) : cmd_seed;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WR, OP_WR_RD: state_next = S_WR;
                        OP_RD:           state_next = S_RD;
                        default:         state_next = S_FIN;
                    endcase
                end
            end
            S_WR: begin
                if (last_ack) begin
                    state_next = (op_reg == OP_WR_RD) ? S_GAP : S_FIN;
                end else if (tmo_hit) begin
                    state_next = S_FIN;
                end
            end
            S_GAP:   state_next = S_RD;
            S_RD: begin
                if (last_ack || tmo_hit) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready      = (state_reg == S_IDLE) & sdr_init_done;
        wb_cyc_o       = in_burst;
        wb_stb_o       = in_burst;
        wb_we_o        = (state_reg == S_WR);
        wb_addr_o      = addr_reg;
        wb_dat_o       = lfsr_reg;
        wb_sel_o       = {SW{in_burst}};
        wb_cti_o       = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
        busy           = (state_reg != S_IDLE);
        done           = (state_reg == S_FIN);
        timeout        = timeout_reg;
        err_cnt        = err_reg;
        first_err_addr = first_reg;
    end

    // Burst datapath: beat/address/LFSR advance together on each ack; the wait
    // counter restarts at every beat start (accept, GAP) and every ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_reg      <= '0;
            start_reg   <= '0;
            addr_reg    <= '0;
            len_m1_reg  <= '0;
            beat_reg    <= '0;
            seed_reg    <= '0;
            lfsr_reg    <= '0;
            wait_reg    <= '0;
            err_reg     <= '0;
            first_reg   <= '0;
            timeout_reg <= 1'b0;
        end else if (accept) begin
            op_reg      <= cmd_op;
            start_reg   <= cmd_addr;
            addr_reg    <= cmd_addr;
            len_m1_reg  <= cmd_len - 8'd1;
            beat_reg    <= '0;
            seed_reg    <= seed_fix;
            lfsr_reg    <= seed_fix;
            wait_reg    <= '0;
            err_reg     <= '0;
            first_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_WR, S_RD: begin
                    if (ack_ok) begin
                        beat_reg <= beat_reg + 8'd1;
                        addr_reg <= addr_reg + APP_AW'(1);
                        lfsr_reg <= lfsr_step;
                        wait_reg <= '0;
                        if (rd_mismatch) begin
                            if (err_reg != '1) begin
                                err_reg <= err_reg + ERR_W'(1);
                            end
                            if (err_reg == '0) begin
                                first_reg <= addr_reg;
                            end
                        end
                    end else if (tmo_hit) begin
                        timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                S_GAP: begin
                    // Rewind for the read-check pass.
                    lfsr_reg <= seed_reg;
                    addr_reg <= start_reg;
                    beat_reg <= '0;
                    wait_reg <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_burst_traffic_gen.md
Name: wb_burst_traffic_gen

Overview:
Hardware Wishbone burst master that sits directly upstream of the SDRAM controller's Wishbone slave port. It generates incrementing write bursts whose data comes from a seeded LFSR. It reads back and checks bursts by regenerating the same LFSR sequence, so no data storage is needed. Used for on-chip SDRAM soak testing and as a synthesizable traffic source in the controller bench.

Parameters:
APP_AW, 26, Wishbone word-address width
DW, 32, data width (sel width = DW/8)
ERR_W, 16, error counter width
ACK_TIMEOUT, 1023, max cycles to wait for wb_ack_i per beat before abort

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset, asynchronous, active-high
sdr_init_done  in  1  SDRAM init complete; gates command acceptance
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 write, 01 read-check, 10 write then read-check, 11 no-op
cmd_addr  in  APP_AW  start word address
cmd_len  in  8  beats; 0 means 256
cmd_seed  in  DW  LFSR seed; 0 is replaced by 1
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  1 write, 0 read
wb_addr_o  out  APP_AW  word address
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte enables, all ones during beats
wb_cti_o  out  3  010 incrementing, 111 last beat
wb_ack_i  in  1  slave acknowledge
wb_dat_i  in  DW  read data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when command completes
timeout  out  1  sticky, set on abort, cleared at next accept
err_cnt  out  ERR_W  saturating mismatch count for the last command
first_err_addr  out  APP_AW  address of first mismatch; valid when err_cnt != 0

Behaviour:
- Reset, asynchronous: state IDLE. cyc, stb, we, done, busy and timeout are 0. addr, dat, sel, cti and err_cnt are 0. first_err_addr is 0. Bus drops in the same instant as reset, including mid-burst.
- cmd_ready = (state==IDLE) & sdr_init_done.
- On accept: latch addr, len and seed. Load the LFSR with the seed. Clear err_cnt, first_err_addr and timeout. Beat counter = 0.
- States:
  - IDLE → WR for op 00/10, → RD for op 01, → FIN for op 11.
  - WR → GAP on last ack when op=10, otherwise → FIN.
  - GAP lasts 1 cycle with cyc=0. It reloads the LFSR from the seed and the address from the start address, then → RD.
  - RD → FIN on last ack.
  - FIN lasts 1 cycle: done=1, cyc=0, then → IDLE.
- Bus timing: cyc and stb assert the cycle after entry to WR or RD. They are held continuously through the burst, with no idle between beats. They are registered low the cycle after the last ack.
- Each beat:
  - wb_addr_o = start + beat, modulo 2^APP_AW (wraps silently).
  - wb_dat_o = current LFSR value.
  - cti = 111 when beat==len-1, otherwise 010; a len=1 burst shows 111 only.
- On each ack (with stb high): advance beat, address and LFSR on the same edge.
- LFSR step: next = {lfsr[DW-2:0],1'b0} ^ (lfsr[DW-1] ? 32'h0040_0007 : 0).
- Read check: on an ack in RD, compare wb_dat_i with the LFSR. On mismatch, err_cnt += 1, saturating at all-ones. first_err_addr is captured only when err_cnt==0.
- Timeout: a wait counter resets on every ack and on beat start. If it reaches ACK_TIMEOUT with no ack, drop cyc/stb, set timeout=1, go to FIN. err_cnt keeps its accumulated value.
- An ack received while stb=0 is ignored.
- cmd_valid while busy is ignored (not queued).
- sdr_init_done falling mid-command does not abort the command.
- err_cnt and first_err_addr stay stable from done until the next accept.

Test Plan:
- Reset release, then sdr_init_done held 0 for 10 cycles with cmd_valid=1 → cmd_ready=0, no cyc. Then init_done=1 → accepted next edge.
- op=00, addr=0x100, len=4, seed=1, slave acks every cycle → addr 0x100..0x103, data 1,2,4,8, cti 010,010,010,111, done 1 cycle after cyc drops.
- op=10, addr=0x3FFFFFE, len=4, seed=1, memory model → write addresses 0x3FFFFFE, 0x3FFFFFF, 0, 1. One cyc-low gap cycle. Read-back finishes with err_cnt=0.
- op=01, seed=0x80000000, len=2, slave returns 0x80000000 then 0xDEADBEEF → expected second word 0x00400007, so err_cnt=1 and first_err_addr=start+1.
- Slave never acks on beat 2 of a len=8 write → cyc drops after ACK_TIMEOUT cycles, timeout=1, done pulses. The next accept clears timeout.
- wb_rst_i asserted mid-burst on beat 3 → cyc/stb/busy go 0 asynchronously. After release, a new command runs normally with err_cnt=0.
